// File: rtl/i_stream_buffer_pkg.sv
// Shared types for the instruction stream buffer (state encoding, entry tag record).
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package i_stream_buffer_pkg;

    localparam int ADDR_WIDTH = 32;
    localparam int DATA_WIDTH = 32;
    localparam int ID_WIDTH   = 4;
    localparam int LEN_WIDTH  = 4;

    typedef enum logic [2:0] {
        SB_IDLE,
        SB_HIT_REPLAY,
        SB_FWD_ADDR,
        SB_FWD_DATA,
        SB_PF_ADDR,
        SB_PF_DATA
    } sb_state_t;

    // Tag side of one buffer entry; the data words live in a separate array
    // whose shape depends on the line-size parameter of the instantiating module.
    typedef struct packed {
        logic                  valid;
        logic [ADDR_WIDTH-1:0] tag;
    } sb_entry_t;

endpackage

// File: rtl/i_stream_buffer_if.sv
// Line-fill read channel (address + data handshakes) between I-cache, buffer and arbiter.
// Latency: n/a (wires only).
// Backpressure: valid/ready on both the address and the data channel.
interface i_stream_buffer_if;
    import i_stream_buffer_pkg::*;

    logic                  arvalid;
    logic                  arready;
    logic [ADDR_WIDTH-1:0] araddr;
    logic [ID_WIDTH-1:0]   arid;
    logic [LEN_WIDTH-1:0]  arlen;
    logic                  rvalid;
    logic                  rready;
    logic                  rlast;
    logic [ID_WIDTH-1:0]   rid;
    logic [DATA_WIDTH-1:0] rdata;

    modport master (
        output arvalid, araddr, arid, arlen, rready,
        input  arready, rvalid, rlast, rid, rdata
    );

    modport slave (
        input  arvalid, araddr, arid, arlen, rready,
        output arready, rvalid, rlast, rid, rdata
    );

endinterface

// File: rtl/i_stream_buffer_sb_line_store.sv
// Line storage for the stream buffer: data words, tags, valid bits and head-tag compare.
// Latency: writes take effect next cycle; read data and hit flag are combinational.
// Backpressure: none; the controller only writes when a beat is accepted.
module sb_line_store
    import i_stream_buffer_pkg::*;
#(
    parameter int DEPTH              = 2,
    parameter int BLOCK_OFFSET_WIDTH = 2,
    localparam int LINE_WORDS        = 1 << BLOCK_OFFSET_WIDTH,
    localparam int PTR_W             = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          flush,
    input  logic                          wr_en,
    input  logic [PTR_W-1:0]              wr_idx,
    input  logic [BLOCK_OFFSET_WIDTH-1:0] wr_beat,
    input  logic [DATA_WIDTH-1:0]         wr_data,
    input  logic                          commit,
    input  logic [ADDR_WIDTH-1:0]         commit_tag,
    input  logic                          pop,
    input  logic [PTR_W-1:0]              rd_idx,
    input  logic [BLOCK_OFFSET_WIDTH-1:0] rd_beat,
    output logic [DATA_WIDTH-1:0]         rd_data,
    input  logic [ADDR_WIDTH-1:0]         lookup_addr,
    output logic                          head_hit
);

    logic [DATA_WIDTH-1:0] data_mem [DEPTH][LINE_WORDS];
    sb_entry_t             entry    [DEPTH];

    // Data words need no reset: an entry is only read after its valid bit is set.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            data_mem[wr_idx][wr_beat] <= wr_data;
        end
    end

    // Tag/valid bookkeeping: flush on a demand miss, set on the last prefetch beat, clear on pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                entry[i] <= '0;
            end
        end else if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                entry[i].valid <= 1'b0;
            end
        end else begin
            if (commit) begin
                entry[wr_idx].valid <= 1'b1;
                entry[wr_idx].tag   <= commit_tag;
            end
            if (pop) begin
                entry[rd_idx].valid <= 1'b0;
            end
        end
    end

    assign rd_data  = data_mem[rd_idx][rd_beat];
    assign head_hit = entry[rd_idx].valid && (entry[rd_idx].tag == lookup_addr);

endmodule

// File: rtl/i_stream_buffer.sv
// Next-line I-prefetcher between I-cache fill port and arbiter read port 0 (I_STREAM_BUFFER_STATS_EN adds hit/miss counters).
// Latency: hit replays from T+1; miss issues downstream address at T+1, data passes through combinationally.
// Backpressure: up_rready stalls replay/forward beats; prefetch holds dn arvalid until accepted and blocks new requests.
module i_stream_buffer
    import i_stream_buffer_pkg::*;
#(
    parameter int DEPTH              = 2,
    parameter int BLOCK_OFFSET_WIDTH = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    i_stream_buffer_if.slave   up,
    i_stream_buffer_if.master  dn
`ifdef I_STREAM_BUFFER_STATS_EN
    ,
    output logic [31:0]        hit_count,
    output logic [31:0]        miss_count
`endif
);

    localparam int LINE_WORDS = 1 << BLOCK_OFFSET_WIDTH;
    localparam int PTR_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W      = $clog2(DEPTH + 1);
    localparam logic [BLOCK_OFFSET_WIDTH-1:0] LAST_BEAT = '1;

    sb_state_t                     state, state_nxt;
    logic [ADDR_WIDTH-1:0]         dem_addr;
    logic [ID_WIDTH-1:0]           dem_id;
    logic [LEN_WIDTH-1:0]          dem_len;
    logic [BLOCK_OFFSET_WIDTH-1:0] beat;
    logic [ADDR_WIDTH-1:0]         pf_addr;
    logic                          pf_armed;
    logic [PTR_W-1:0]              head, tail;
    logic [CNT_W-1:0]              count;

    logic                          head_hit;
    logic                          hit;
    logic                          req_accept;
    logic                          pf_beat;
    logic                          pf_done;
    logic                          replay_done;
    logic [DATA_WIDTH-1:0]         store_rd_data;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign req_accept  = (state == SB_IDLE) && up.arvalid;
    assign hit         = head_hit && (count != '0);
    assign pf_beat     = (state == SB_PF_DATA) && dn.rvalid;
    assign pf_done     = pf_beat && dn.rlast;
    assign replay_done = (state == SB_HIT_REPLAY) && up.rready && (beat == LAST_BEAT);

    sb_line_store #(
        .DEPTH              (DEPTH),
        .BLOCK_OFFSET_WIDTH (BLOCK_OFFSET_WIDTH)
    ) u_store (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (req_accept && !hit),
        .wr_en       (pf_beat),
        .wr_idx      (tail),
        .wr_beat     (beat),
        .wr_data     (dn.rdata),
        .commit      (pf_done),
        .commit_tag  (pf_addr),
        .pop         (replay_done),
        .rd_idx      (head),
        .rd_beat     (beat),
        .rd_data     (store_rd_data),
        .lookup_addr (up.araddr),
        .head_hit    (head_hit)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= SB_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and channel outputs; demand requests take priority over starting a prefetch.
    always_comb begin
        state_nxt  = state;
        up.arready = 1'b0;
        up.rvalid  = 1'b0;
        up.rlast   = 1'b0;
        up.rid     = '0;
        up.rdata   = '0;
        dn.arvalid = 1'b0;
        dn.araddr  = '0;
        dn.arid    = '0;
        dn.arlen   = '0;
        dn.rready  = 1'b0;
        case (state)
            SB_IDLE: begin
                up.arready = up.arvalid;
                if (up.arvalid) begin
                    state_nxt = hit ? SB_HIT_REPLAY : SB_FWD_ADDR;
                end else if (pf_armed && (count < CNT_W'(DEPTH))) begin
                    state_nxt = SB_PF_ADDR;
                end
            end
            SB_HIT_REPLAY: begin
                up.rvalid = 1'b1;
                up.rdata  = store_rd_data;
                up.rid    = dem_id;
                up.rlast  = (beat == LAST_BEAT);
                if (replay_done) begin
                    state_nxt = SB_IDLE;
                end
            end
            SB_FWD_ADDR: begin
                dn.arvalid = 1'b1;
                dn.araddr  = dem_addr;
                dn.arid    = dem_id;
                dn.arlen   = dem_len;
                if (dn.arready) begin
                    state_nxt = SB_FWD_DATA;
                end
            end
            SB_FWD_DATA: begin
                up.rvalid = dn.rvalid;
                up.rdata  = dn.rdata;
                up.rlast  = dn.rlast;
                up.rid    = dn.rid;
                dn.rready = up.rready;
                if (dn.rvalid && up.rready && dn.rlast) begin
                    state_nxt = SB_IDLE;
                end
            end
            SB_PF_ADDR: begin
                dn.arvalid = 1'b1;
                dn.araddr  = pf_addr;
                dn.arid    = dem_id;
                dn.arlen   = LEN_WIDTH'(LINE_WORDS - 1);
                if (dn.arready) begin
                    state_nxt = SB_PF_DATA;
                end
            end
            SB_PF_DATA: begin
                dn.rready = 1'b1;
                if (pf_done) begin
                    state_nxt = SB_IDLE;
                end
            end
            default: state_nxt = SB_IDLE;
        endcase
    end

    // Demand latch, beat counter, FIFO pointers and prefetch address tracking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dem_addr <= '0;
            dem_id   <= '0;
            dem_len  <= '0;
            beat     <= '0;
            pf_addr  <= '0;
            pf_armed <= 1'b0;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
        end else begin
            if (req_accept) begin
                dem_addr <= up.araddr;
                dem_id   <= up.arid;
                dem_len  <= up.arlen;
                if (!hit) begin
                    // Miss restarts the stream right after the demanded line.
                    count    <= '0;
                    head     <= '0;
                    tail     <= '0;
                    pf_addr  <= up.araddr + ADDR_WIDTH'(LINE_WORDS);
                    pf_armed <= 1'b1;
                end
            end
            if ((state == SB_HIT_REPLAY) && up.rready) begin
                beat <= beat + 1'b1;
            end
            if (replay_done) begin
                head  <= ptr_inc(head);
                count <= count - 1'b1;
            end
            if (pf_beat) begin
                beat <= dn.rlast ? '0 : beat + 1'b1;
            end
            if (pf_done) begin
                tail    <= ptr_inc(tail);
                count   <= count + 1'b1;
                pf_addr <= pf_addr + ADDR_WIDTH'(LINE_WORDS);
            end
        end
    end

`ifdef I_STREAM_BUFFER_STATS_EN
    // Saturating classification counters for accepted demand requests.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (req_accept) begin
            if (hit) begin
                if (hit_count != '1) hit_count <= hit_count + 1'b1;
            end else begin
                if (miss_count != '1) miss_count <= miss_count + 1'b1;
            end
        end
    end
`endif

endmodule
